tug_game_ctrl: RTL and testbench

TUG_GAME_CTRL -- requirements
Module: tug_game_ctrl

---
 rtl/tug_pkg.sv | 42 ++++
 rtl/btn_edge.sv | 52 +++++
 rtl/tug_game_ctrl.sv | 99 +++++++++
 tb/tb_tug_game_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared state encoding and screen codes for the tug-of-war controller and its display stage.
package tug_pkg;

  localparam int unsigned SCR_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    CNT3,
    CNT2,
    CNT1,
    GO,
    PLAY,
    WIN1,
    WIN2
  } state_t;

  localparam logic [SCR_W-1:0] SCR_BLANK    = 6'd0;
  localparam logic [SCR_W-1:0] SCR_PLAY_MIN = 6'd16;
  localparam logic [SCR_W-1:0] SCR_PLAY_MID = 6'd23;
  localparam logic [SCR_W-1:0] SCR_PLAY_MAX = 6'd30;
  localparam logic [SCR_W-1:0] SCR_GO       = 6'd31;
  localparam logic [SCR_W-1:0] SCR_ONE      = 6'd32;
  localparam logic [SCR_W-1:0] SCR_TWO      = 6'd33;
  localparam logic [SCR_W-1:0] SCR_THREE    = 6'd34;
  localparam logic [SCR_W-1:0] SCR_P2WIN    = 6'd35;
  localparam logic [SCR_W-1:0] SCR_P1WIN    = 6'd36;

  // Screen code shown for a given state; in PLAY the rope position is the code.
  function automatic logic [SCR_W-1:0] state_screen(input state_t st, input logic [SCR_W-1:0] pos);
    case (st)
      CNT3:    return SCR_THREE;
      CNT2:    return SCR_TWO;
      CNT1:    return SCR_ONE;
      GO:      return SCR_GO;
      PLAY:    return pos;
      WIN1:    return SCR_P1WIN;
      WIN2:    return SCR_P2WIN;
      default: return SCR_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button front end: 2-flop synchronizer, rising-edge detect and optional post-press lockout.
module btn_edge #(
  parameter int unsigned LOCKOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press_c
);

  localparam int unsigned   CW       = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam bit            HAS_LOCK = (LOCKOUT > 0);
  localparam logic [CW-1:0] LAST     = CW'((LOCKOUT > 0) ? (LOCKOUT - 1) : 0);

  logic [1:0]    r_sync;
  logic [1:0]    r_settle;
  logic          r_prev;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic          w_edge;

  // r_prev is held high until the synchronizer has settled, so a button
  // already down at reset release must be released before it counts.
  assign w_edge    = r_settle[1] & r_sync[1] & ~r_prev;
  assign o_press_c = w_edge & ~r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_settle <= '0;
      r_prev   <= 1'b1;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync   <= {r_sync[0], i_btn};
      r_settle <= {r_settle[0], 1'b1};
      r_prev   <= r_settle[1] ? r_sync[1] : 1'b1;
      if (o_press_c && HAS_LOCK) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_busy) begin
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tug_game_ctrl.sv
// Tug-of-war game controller: countdown, rope position tracking and winner screens.
module tug_game_ctrl
  import tug_pkg::*;
#(
  parameter int unsigned STEP_CYCLES    = 1500000,
  parameter int unsigned LOCKOUT_CYCLES = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_btn,
  input  logic       p2_btn,
  output logic [5:0] screen,
  output logic       playing
);

  localparam int unsigned   SW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'((STEP_CYCLES > 0) ? (STEP_CYCLES - 1) : 0);

  state_t           r_state, w_state_nxt;
  logic [SCR_W-1:0] r_pos, w_pos_nxt;
  logic [SW-1:0]    r_cnt, w_cnt_nxt;
  logic [SCR_W-1:0] r_screen, w_screen_nxt;
  logic             r_playing, w_playing_nxt;
  logic             w_start, w_p1, w_p2;

  btn_edge #(.LOCKOUT(0)) u_start (
    .clk(clk), .rst_n(reset), .i_btn(start), .o_press_c(w_start)
  );
  btn_edge #(.LOCKOUT(LOCKOUT_CYCLES)) u_p1 (
    .clk(clk), .rst_n(reset), .i_btn(p1_btn), .o_press_c(w_p1)
  );
  btn_edge #(.LOCKOUT(LOCKOUT_CYCLES)) u_p2 (
    .clk(clk), .rst_n(reset), .i_btn(p2_btn), .o_press_c(w_p2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pos     <= SCR_PLAY_MID;
      r_cnt     <= '0;
      r_screen  <= SCR_BLANK;
      r_playing <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_cnt     <= w_cnt_nxt;
      r_screen  <= w_screen_nxt;
      r_playing <= w_playing_nxt;
    end
  end

  // Outputs reflect the current state, so they lag each state change by one cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_cnt_nxt     = r_cnt;
    w_screen_nxt  = state_screen(r_state, r_pos);
    w_playing_nxt = (r_state == PLAY);
    case (r_state)
      IDLE, WIN1, WIN2: begin
        if (w_start) begin
          w_state_nxt = CNT3;
          w_cnt_nxt   = '0;
        end
      end
      CNT3, CNT2, CNT1, GO: begin
        if (r_cnt == STEP_LAST) begin
          w_cnt_nxt = '0;
          case (r_state)
            CNT3:    w_state_nxt = CNT2;
            CNT2:    w_state_nxt = CNT1;
            CNT1:    w_state_nxt = GO;
            default: begin
              w_state_nxt = PLAY;
              w_pos_nxt   = SCR_PLAY_MID;
            end
          endcase
        end else begin
          w_cnt_nxt = r_cnt + SW'(1);
        end
      end
      PLAY: begin
        if (w_p1 && !w_p2) begin
          if (r_pos == SCR_PLAY_MAX) w_state_nxt = WIN1;
          else                       w_pos_nxt   = r_pos + SCR_W'(1);
        end else if (w_p2 && !w_p1) begin
          if (r_pos == SCR_PLAY_MIN) w_state_nxt = WIN2;
          else                       w_pos_nxt   = r_pos - SCR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign screen  = r_screen;
  assign playing = r_playing;

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Scoreboard bench for tug_game_ctrl: expected screen/playing changes queued, compared on change.
module tb_tug_game_ctrl;

  typedef struct packed {
    logic [5:0] scr;
    logic       ply;
    logic [7:0] dwell;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_btn = 1'b0;
  logic       p2_btn = 1'b0;
  logic [5:0] screen;
  logic       playing;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  bit   mon_en = 1'b0;

  tug_game_ctrl #(.STEP_CYCLES(4), .LOCKOUT_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .p1_btn(p1_btn), .p2_btn(p2_btn),
    .screen(screen), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_scr(input logic [5:0] s, input logic p, input logic [7:0] d);
    exp_t e;
    e.scr = s; e.ply = p; e.dwell = d;
    q.push_back(e);
  endtask

  // Monitor: each change of {screen,playing} consumes one expected entry.
  logic [6:0] m_last;
  int         m_cyc = 0;
  int         m_last_t = 0;
  logic [7:0] m_dwell = 8'd0;
  always @(negedge clk) begin
    if (mon_en) begin
      m_cyc++;
      if ({screen, playing} != m_last) begin
        if (m_dwell != 8'd0) check("dwell", m_cyc - m_last_t, int'(m_dwell));
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_change: got screen %0d playing %0d, expected no change", screen, playing);
          m_dwell = 8'd0;
        end else begin
          exp_t e;
          e = q.pop_front();
          check("screen", int'(screen), int'(e.scr));
          check("playing", int'(playing), int'(e.ply));
          m_dwell = e.dwell;
        end
        m_last   = {screen, playing};
        m_last_t = m_cyc;
      end
    end
  end

  task automatic wait_scr(input logic [5:0] v, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (screen == v) seen = 1'b1;
    end
    if (!seen) check("wait_screen_timeout", 0, int'(v));
  endtask

  task automatic press(input bit do1, input bit do2);
    @(negedge clk);
    if (do1) p1_btn = 1'b1;
    if (do2) p2_btn = 1'b1;
    repeat (2) @(negedge clk);
    p1_btn = 1'b0;
    p2_btn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_countdown();
    expect_scr(6'd34, 1'b0, 8'd4);
    expect_scr(6'd33, 1'b0, 8'd4);
    expect_scr(6'd32, 1'b0, 8'd4);
    expect_scr(6'd31, 1'b0, 8'd4);
    expect_scr(6'd23, 1'b1, 8'd0);
  endtask

  initial begin
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_screen", int'(screen), 0);
    check("reset_playing", int'(playing), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    m_last = {screen, playing};
    mon_en = 1'b1;

    // Countdown with presses during CNT3..GO, play still starts at 23
    expect_countdown();
    pulse_start();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    wait_scr(6'd23, 40);
    repeat (4) @(negedge clk);

    // p1 walks the rope to 30, then wins
    for (int i = 24; i <= 30; i++) begin
      expect_scr(6'(i), 1'b1, 8'd0);
      press(1'b1, 1'b0);
    end
    expect_scr(6'd36, 1'b0, 8'd0);
    press(1'b1, 1'b0);

    // Restart from WIN1; simultaneous presses cancel; double press within lockout
    expect_countdown();
    pulse_start();
    wait_scr(6'd23, 40);
    repeat (4) @(negedge clk);
    press(1'b1, 1'b1);
    expect_scr(6'd24, 1'b1, 8'd0);
    @(negedge clk); p1_btn = 1'b1;
    @(negedge clk); p1_btn = 1'b0;
    @(negedge clk); p1_btn = 1'b1;
    repeat (2) @(negedge clk); p1_btn = 1'b0;
    repeat (8) @(negedge clk);

    // p2 walks the rope down to 16, then wins; start restarts
    for (int i = 23; i >= 16; i--) begin
      expect_scr(6'(i), 1'b1, 8'd0);
      press(1'b0, 1'b1);
    end
    expect_scr(6'd35, 1'b0, 8'd0);
    press(1'b0, 1'b1);
    expect_scr(6'd34, 1'b0, 8'd4);
    expect_scr(6'd33, 1'b0, 8'd0);
    pulse_start();
    wait_scr(6'd33, 20);

    // Reset in CNT2 with p1 held through release
    p1_btn = 1'b1;
    repeat (2) @(negedge clk);
    expect_scr(6'd0, 1'b0, 8'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_screen", int'(screen), 0);
    check("midreset_playing", int'(playing), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    expect_countdown();
    pulse_start();
    wait_scr(6'd23, 40);
    repeat (10) @(negedge clk);
    p1_btn = 1'b0;
    repeat (4) @(negedge clk);
    expect_scr(6'd24, 1'b1, 8'd0);
    press(1'b1, 1'b0);

    repeat (10) @(negedge clk);
    check("pending_expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
